// File: rtl/peri_bridge_n.sv
// peri_bridge_n: CPU-bus bridge that splits accesses between DRAM and up to
// NUM_CH memory-mapped I/O channels.
//
// Address decode: addr[ADDR_W-1:12] == IO_BASE selects the I/O region,
// addr[11:8] selects the channel and addr[7:0] is the channel-local offset.
// Everything else passes straight through to DRAM. Read data is registered
// (one cycle latency) and held until the next response.
//
// Optional feature: define PERI_BRIDGE_WBUF_EN to build a posted-write
// buffer for I/O writes. Without it, I/O writes go out combinationally.
//
// Ports:
//   cpu_clk, cpu_rst_n           clock, asynchronous active-low reset
//   bus_addr/wen/ren/wdata       CPU request
//   bus_ready                    request accepted this cycle
//   bus_rvalid/bus_rdata         registered read response
//   dram_addr/wen/wdata/rdata    DRAM pass-through
//   io_addr/wen/wdata/rdata      I/O channels (io_wen one-hot, io_rdata sliced)
//   wbuf_level                   occupied posted-write entries
//   err_cnt                      saturating decode-error count
module peri_bridge_n #(
    parameter int                 DATA_W     = 32,
    parameter int                 ADDR_W     = 32,
    parameter int                 NUM_CH     = 4,
    parameter int                 WBUF_DEPTH = 4,
    parameter logic [ADDR_W-13:0] IO_BASE    = '1
) (
    input  logic                        cpu_clk,
    input  logic                        cpu_rst_n,
    input  logic [ADDR_W-1:0]           bus_addr,
    input  logic                        bus_wen,
    input  logic                        bus_ren,
    input  logic [DATA_W-1:0]           bus_wdata,
    output logic                        bus_ready,
    output logic                        bus_rvalid,
    output logic [DATA_W-1:0]           bus_rdata,
    output logic [ADDR_W-1:0]           dram_addr,
    output logic                        dram_wen,
    output logic [DATA_W-1:0]           dram_wdata,
    input  logic [DATA_W-1:0]           dram_rdata,
    output logic [7:0]                  io_addr,
    output logic [NUM_CH-1:0]           io_wen,
    output logic [DATA_W-1:0]           io_wdata,
    input  logic [NUM_CH*DATA_W-1:0]    io_rdata,
    output logic [$clog2(WBUF_DEPTH):0] wbuf_level,
    output logic [7:0]                  err_cnt
);

    typedef enum logic [1:0] {IDLE, WAIT_DRAIN, RESP} rd_state_t;

    localparam logic [4:0] NCH5 = 5'(NUM_CH);

    rd_state_t         state;
    logic              io_hit;
    logic [3:0]        chan;
    logic              ch_err;
    logic              dual;
    logic              io_wr_req;
    logic              io_rd_req;
    logic              rd_block;
    logic              wr_block;
    logic              rd_acc;
    logic              err_inc;
    logic              wbuf_empty;
    logic [DATA_W-1:0] io_sel_rdata;

    assign io_hit    = (bus_addr[ADDR_W-1:12] == IO_BASE);
    assign chan      = bus_addr[11:8];
    assign ch_err    = io_hit && ({1'b0, chan} >= NCH5);
    assign dual      = bus_wen && bus_ren;
    assign io_wr_req = bus_wen && io_hit && !ch_err;
    assign io_rd_req = bus_ren && !bus_wen && io_hit;

    // An I/O read must not overtake posted writes, so it waits for an empty buffer.
    assign rd_block  = io_rd_req && !wbuf_empty;
    assign bus_ready = !rd_block && !wr_block;
    assign rd_acc    = bus_ren && !bus_wen && bus_ready;
    // Counted on acceptance so a stalled request is counted once.
    assign err_inc   = (bus_wen || bus_ren) && bus_ready && (dual || ch_err);

    assign dram_addr  = bus_addr;
    assign dram_wdata = bus_wdata;
    assign dram_wen   = bus_wen && !io_hit && bus_ready;

    always_comb begin
        io_sel_rdata = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            if (chan == 4'(k)) io_sel_rdata = io_rdata[k*DATA_W +: DATA_W];
        end
    end

`ifdef PERI_BRIDGE_WBUF_EN
    localparam int PTR_W = $clog2(WBUF_DEPTH);

    logic [3:0]        q_ch   [WBUF_DEPTH];
    logic [7:0]        q_off  [WBUF_DEPTH];
    logic [DATA_W-1:0] q_data [WBUF_DEPTH];
    logic [PTR_W-1:0]  wr_ptr;
    logic [PTR_W-1:0]  rd_ptr;
    logic [PTR_W:0]    level;
    logic              full;
    logic              push;
    logic              pop;
    logic              draining;

    assign wbuf_empty = (level == '0);
    assign full       = (level == (PTR_W+1)'(WBUF_DEPTH));
    assign wr_block   = io_wr_req && full;
    assign push       = io_wr_req && !full;
    // Entries accumulate while the CPU streams I/O writes; draining starts when
    // the CPU leaves the I/O write path or the buffer fills, and once started
    // continues every cycle (alongside new pushes) until empty.
    assign pop        = !wbuf_empty && (draining || full || !io_wr_req);

    assign wbuf_level = level;
    assign io_wdata   = q_data[rd_ptr];
    assign io_addr    = pop ? q_off[rd_ptr] : bus_addr[7:0];

    always_comb begin
        io_wen = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            io_wen[k] = pop && (q_ch[rd_ptr] == 4'(k));
        end
    end

    always_ff @(posedge cpu_clk) begin
        if (push) begin
            q_ch[wr_ptr]   <= chan;
            q_off[wr_ptr]  <= bus_addr[7:0];
            q_data[wr_ptr] <= bus_wdata;
        end
    end

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            wr_ptr   <= '0;
            rd_ptr   <= '0;
            level    <= '0;
            draining <= 1'b0;
        end else begin
            draining <= pop;
            if (push) wr_ptr <= wr_ptr + PTR_W'(1);
            if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
            case ({push, pop})
                2'b10:   level <= level + (PTR_W+1)'(1);
                2'b01:   level <= level - (PTR_W+1)'(1);
                default: level <= level;
            endcase
        end
    end
`else
    assign wbuf_empty = 1'b1;
    assign wr_block   = 1'b0;
    assign wbuf_level = '0;
    assign io_wdata   = bus_wdata;
    assign io_addr    = bus_addr[7:0];

    always_comb begin
        io_wen = '0;
        for (int unsigned k = 0; k < NUM_CH; k++) begin
            io_wen[k] = io_wr_req && (chan == 4'(k));
        end
    end
`endif

    assign bus_rvalid = (state == RESP);

    always_ff @(posedge cpu_clk or negedge cpu_rst_n) begin
        if (!cpu_rst_n) begin
            state     <= IDLE;
            bus_rdata <= '0;
            err_cnt   <= '0;
        end else begin
            if (rd_acc) begin
                state     <= RESP;
                bus_rdata <= io_hit ? (ch_err ? '0 : io_sel_rdata) : dram_rdata;
            end else if (rd_block) begin
                state <= WAIT_DRAIN;
            end else begin
                state <= IDLE;
            end
            if (err_inc && (err_cnt != 8'hFF)) err_cnt <= err_cnt + 8'd1;
        end
    end

endmodule

// File: tb/tb_peri_bridge_n.sv
module tb_peri_bridge_n;

    localparam int NCH   = 4;
    localparam int DEPTH = 4;
`ifdef PERI_BRIDGE_WBUF_EN
    localparam bit WB = 1'b1;
`else
    localparam bit WB = 1'b0;
`endif

    logic          cpu_clk;
    logic          cpu_rst_n;
    logic [31:0]   bus_addr;
    logic          bus_wen;
    logic          bus_ren;
    logic [31:0]   bus_wdata;
    logic          bus_ready;
    logic          bus_rvalid;
    logic [31:0]   bus_rdata;
    logic [31:0]   dram_addr;
    logic          dram_wen;
    logic [31:0]   dram_wdata;
    logic [31:0]   dram_rdata;
    logic [7:0]    io_addr;
    logic [3:0]    io_wen;
    logic [31:0]   io_wdata;
    logic [127:0]  io_rdata;
    logic [2:0]    wbuf_level;
    logic [7:0]    err_cnt;

    peri_bridge_n #(
        .DATA_W(32), .ADDR_W(32), .NUM_CH(NCH), .WBUF_DEPTH(DEPTH)
    ) dut (
        .cpu_clk(cpu_clk), .cpu_rst_n(cpu_rst_n),
        .bus_addr(bus_addr), .bus_wen(bus_wen), .bus_ren(bus_ren),
        .bus_wdata(bus_wdata), .bus_ready(bus_ready), .bus_rvalid(bus_rvalid),
        .bus_rdata(bus_rdata), .dram_addr(dram_addr), .dram_wen(dram_wen),
        .dram_wdata(dram_wdata), .dram_rdata(dram_rdata), .io_addr(io_addr),
        .io_wen(io_wen), .io_wdata(io_wdata), .io_rdata(io_rdata),
        .wbuf_level(wbuf_level), .err_cnt(err_cnt)
    );

    initial cpu_clk = 1'b0;
    always #5 cpu_clk = ~cpu_clk;

    int checks = 0;
    int errors = 0;

    // Fixed per-channel read data: channel k returns 0x11111111*(k+1).
    function automatic logic [31:0] ch_data(input logic [3:0] ch);
        return 32'h1111_1111 * (32'(ch) + 32'd1);
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h, expected %h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Reference model: pending posted writes as a queue, plus response/error state.
    typedef struct packed {
        logic [3:0]  ch;
        logic [7:0]  off;
        logic [31:0] data;
    } ent_t;

    ent_t        q[$];
    bit          m_drain;
    bit          m_rvalid;
    logic [31:0] m_rdata;
    int          m_err;

    logic        s_ready;
    logic        s_dwen;
    logic [3:0]  s_io_wen;
    logic [31:0] s_io_wdata;
    logic [7:0]  s_io_addr;

    task automatic model_reset();
        q.delete();
        m_drain  = 0;
        m_rvalid = 0;
        m_rdata  = '0;
        m_err    = 0;
    endtask

    task automatic set_req(input logic [31:0] a, input logic w, input logic r, input logic [31:0] d);
        bus_addr  = a;
        bus_wen   = w;
        bus_ren   = r;
        bus_wdata = d;
    endtask

    // One bus cycle: compare every output at the negedge, then advance the model at the posedge.
    task automatic tick();
        bit          hit, cerr, iowr, iord, full, rdy, pop, acc;
        logic [3:0]  ch;
        logic [3:0]  ewen;
        logic [31:0] ewdata;
        logic [7:0]  eaddr;
        @(negedge cpu_clk);
        #1;
        hit    = (bus_addr[31:12] == 20'hFFFFF);
        ch     = bus_addr[11:8];
        cerr   = hit && (ch >= 4'(NCH));
        iowr   = bus_wen && hit && !cerr;
        iord   = bus_ren && !bus_wen && hit;
        full   = WB && (q.size() == DEPTH);
        rdy    = !(iord && q.size() != 0) && !(iowr && full);
        pop    = WB && (q.size() != 0) && (m_drain || full || !iowr);
        ewen   = '0;
        ewdata = bus_wdata;
        eaddr  = bus_addr[7:0];
        if (pop) begin
            ewen   = 4'b0001 << q[0].ch;
            ewdata = q[0].data;
            eaddr  = q[0].off;
        end else if (!WB && iowr) begin
            ewen = 4'b0001 << ch;
        end
        chk("bus_ready", 32'(bus_ready), 32'(rdy));
        chk("dram_wen", 32'(dram_wen), 32'(bus_wen && !hit && rdy));
        chk("dram_addr", dram_addr, bus_addr);
        chk("dram_wdata", dram_wdata, bus_wdata);
        chk("io_wen", 32'(io_wen), 32'(ewen));
        if (ewen != 0) chk("io_wdata", io_wdata, ewdata);
        chk("io_addr", 32'(io_addr), 32'(eaddr));
        chk("bus_rvalid", 32'(bus_rvalid), 32'(m_rvalid));
        chk("bus_rdata", bus_rdata, m_rdata);
        chk("wbuf_level", 32'(wbuf_level), 32'(q.size()));
        chk("err_cnt", 32'(err_cnt), 32'(m_err));
        s_ready    = bus_ready;
        s_dwen     = dram_wen;
        s_io_wen   = io_wen;
        s_io_wdata = io_wdata;
        s_io_addr  = io_addr;
        @(posedge cpu_clk);
        acc      = bus_ren && !bus_wen && rdy;
        m_rvalid = acc;
        if (acc) m_rdata = hit ? (cerr ? 32'h0 : ch_data(ch)) : dram_rdata;
        if ((bus_wen || bus_ren) && rdy && ((bus_wen && bus_ren) || cerr) && m_err < 255) m_err++;
        if (pop) void'(q.pop_front());
        if (WB && iowr && !full) q.push_back('{ch, bus_addr[7:0], bus_wdata});
        m_drain = pop;
        #1;
    endtask

    // Assert reset with idle inputs, check the forced values, release after two edges.
    task automatic do_reset();
        set_req(32'h0, 1'b0, 1'b0, 32'h0);
        cpu_rst_n = 1'b0;
        model_reset();
        #1;
        chk("rst bus_ready", 32'(bus_ready), 32'd1);
        chk("rst bus_rvalid", 32'(bus_rvalid), 32'd0);
        chk("rst bus_rdata", bus_rdata, 32'd0);
        chk("rst io_wen", 32'(io_wen), 32'd0);
        chk("rst wbuf_level", 32'(wbuf_level), 32'd0);
        chk("rst err_cnt", 32'(err_cnt), 32'd0);
        repeat (2) @(posedge cpu_clk);
        #1;
        cpu_rst_n = 1'b1;
    endtask

    typedef struct {
        logic [31:0] addr;
        logic        wen;
        logic        ren;
        logic [31:0] wdata;
        logic [31:0] drd;
        logic        e_ready;
        logic        e_dwen;
        logic        e_rvalid;
        logic [31:0] e_rdata;
        logic [7:0]  e_err;
    } vec_t;

    vec_t tbl[11];

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        io_rdata   = {32'h4444_4444, 32'h3333_3333, 32'h2222_2222, 32'h1111_1111};
        dram_rdata = '0;
        set_req(32'h0, 1'b0, 1'b0, 32'h0);
        cpu_rst_n  = 1'b0;

        // addr, wen, ren, wdata, dram_rdata | ready, dram_wen, rvalid(next), rdata(next), err(next)
        tbl[0]  = '{32'h0000_0010, 1'b0, 1'b1, 32'h0,         32'h1234_5678, 1'b1, 1'b0, 1'b1, 32'h1234_5678, 8'd0};
        tbl[1]  = '{32'h0000_0020, 1'b1, 1'b0, 32'hDEAD_BEEF, 32'h0,         1'b1, 1'b1, 1'b0, 32'h1234_5678, 8'd0};
        tbl[2]  = '{32'hFFFF_F104, 1'b0, 1'b1, 32'h0,         32'h0,         1'b1, 1'b0, 1'b1, 32'h2222_2222, 8'd0};
        tbl[3]  = '{32'hFFFF_F700, 1'b0, 1'b1, 32'h0,         32'h9999_9999, 1'b1, 1'b0, 1'b1, 32'h0000_0000, 8'd1};
        tbl[4]  = '{32'h0000_0000, 1'b0, 1'b0, 32'h0,         32'h0,         1'b1, 1'b0, 1'b0, 32'h0000_0000, 8'd1};
        tbl[5]  = '{32'h0000_0020, 1'b1, 1'b1, 32'h55AA_55AA, 32'h0,         1'b1, 1'b1, 1'b0, 32'h0000_0000, 8'd2};
        tbl[6]  = '{32'hFFFF_F700, 1'b1, 1'b0, 32'h0000_0077, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0000_0000, 8'd3};
        tbl[7]  = '{32'hFFFF_E010, 1'b0, 1'b1, 32'h0,         32'hCAFE_BABE, 1'b1, 1'b0, 1'b1, 32'hCAFE_BABE, 8'd3};
        tbl[8]  = '{32'hFFFF_F3FF, 1'b0, 1'b1, 32'h0,         32'h0,         1'b1, 1'b0, 1'b1, 32'h4444_4444, 8'd3};
        tbl[9]  = '{32'h0001_F0F0, 1'b0, 1'b1, 32'h0,         32'h0BAD_F00D, 1'b1, 1'b0, 1'b1, 32'h0BAD_F00D, 8'd3};
        tbl[10] = '{32'hFFFF_F500, 1'b1, 1'b1, 32'h0000_0011, 32'h0,         1'b1, 1'b0, 1'b0, 32'h0BAD_F00D, 8'd4};

        #2;
        do_reset();

        // Table-driven decode/read-path vectors; none of them pushes a valid I/O write.
        for (int i = 0; i < 11; i++) begin
            set_req(tbl[i].addr, tbl[i].wen, tbl[i].ren, tbl[i].wdata);
            dram_rdata = tbl[i].drd;
            tick();
            chk($sformatf("vec%0d ready", i), 32'(s_ready), 32'(tbl[i].e_ready));
            chk($sformatf("vec%0d dram_wen", i), 32'(s_dwen), 32'(tbl[i].e_dwen));
            chk($sformatf("vec%0d io_wen", i), 32'(s_io_wen), 32'd0);
            chk($sformatf("vec%0d rvalid", i), 32'(bus_rvalid), 32'(tbl[i].e_rvalid));
            chk($sformatf("vec%0d rdata", i), bus_rdata, tbl[i].e_rdata);
            chk($sformatf("vec%0d err_cnt", i), 32'(err_cnt), 32'(tbl[i].e_err));
        end
        set_req(32'h0, 1'b0, 1'b0, 32'h0);
        tick();

`ifdef PERI_BRIDGE_WBUF_EN
        // Five back-to-back writes to channel 1 with a 4-deep buffer.
        do_reset();
        for (int c = 0; c < 9; c++) begin
            if (c < 4)      set_req(32'hFFFF_F104, 1'b1, 1'b0, 32'(c + 1));
            else if (c < 6) set_req(32'hFFFF_F104, 1'b1, 1'b0, 32'd5);
            else            set_req(32'h0, 1'b0, 1'b0, 32'h0);
            tick();
            chk($sformatf("burst c%0d ready", c), 32'(s_ready), (c == 4) ? 32'd0 : 32'd1);
            chk($sformatf("burst c%0d io_wen", c), 32'(s_io_wen), (c >= 4) ? 32'h2 : 32'h0);
            if (c >= 4) chk($sformatf("burst c%0d io_wdata", c), s_io_wdata, 32'(c - 3));
            if (c >= 4) chk($sformatf("burst c%0d io_addr", c), 32'(s_io_addr), 32'h04);
        end
        chk("burst final level", 32'(wbuf_level), 32'd0);

        // Write to channel 2 then immediately read it back.
        do_reset();
        set_req(32'hFFFF_F200, 1'b1, 1'b0, 32'h0000_00A5);
        tick();
        chk("raw write ready", 32'(s_ready), 32'd1);
        set_req(32'hFFFF_F200, 1'b0, 1'b1, 32'h0);
        tick();
        chk("raw stall ready", 32'(s_ready), 32'd0);
        chk("raw drain io_wen", 32'(s_io_wen), 32'h4);
        chk("raw drain io_wdata", s_io_wdata, 32'h0000_00A5);
        tick();
        chk("raw accept ready", 32'(s_ready), 32'd1);
        chk("raw rvalid", 32'(bus_rvalid), 32'd1);
        chk("raw rdata", bus_rdata, 32'h3333_3333);
        set_req(32'h0, 1'b0, 1'b0, 32'h0);
        tick();
        chk("raw rvalid one cycle", 32'(bus_rvalid), 32'd0);
`else
        // Unbuffered: I/O write appears on io_wen in the same cycle, reads never stall.
        do_reset();
        set_req(32'hFFFF_F104, 1'b1, 1'b0, 32'h0000_0005);
        tick();
        chk("direct io_wen", 32'(s_io_wen), 32'h2);
        chk("direct io_wdata", s_io_wdata, 32'h0000_0005);
        chk("direct level", 32'(wbuf_level), 32'd0);
        set_req(32'hFFFF_F200, 1'b1, 1'b0, 32'h0000_00A5);
        tick();
        chk("direct wr ready", 32'(s_ready), 32'd1);
        set_req(32'hFFFF_F200, 1'b0, 1'b1, 32'h0);
        tick();
        chk("direct rd ready", 32'(s_ready), 32'd1);
        chk("direct rvalid", 32'(bus_rvalid), 32'd1);
        chk("direct rdata", bus_rdata, 32'h3333_3333);
`endif

        // Reset with three writes in flight: nothing may be issued afterwards.
        do_reset();
        for (int c = 0; c < 3; c++) begin
            set_req({20'hFFFFF, 4'(c), 8'h10}, 1'b1, 1'b0, 32'hF00 + 32'(c));
            tick();
        end
        chk("pre-reset level", 32'(wbuf_level), WB ? 32'd3 : 32'd0);
        do_reset();
        for (int c = 0; c < 6; c++) begin
            tick();
            chk($sformatf("post-reset c%0d io_wen", c), 32'(s_io_wen), 32'd0);
        end

        // Error counter: first error and saturation.
        do_reset();
        set_req(32'hFFFF_F700, 1'b1, 1'b0, 32'h1);
        tick();
        chk("err first io_wen", 32'(s_io_wen), 32'd0);
        chk("err first count", 32'(err_cnt), 32'd1);
        for (int c = 1; c < 300; c++) tick();
        chk("err saturate", 32'(err_cnt), 32'd255);

        // Randomized traffic against the model; a stalled request is held unchanged.
        do_reset();
        s_ready = 1'b1;
        for (int i = 0; i < 3000; i++) begin
            if (s_ready || !(bus_wen || bus_ren)) begin
                int unsigned r;
                logic [31:0] a;
                r = $urandom_range(0, 9);
                if ($urandom_range(0, 1) == 0) a = $urandom;
                else a = {20'hFFFFF, 4'($urandom_range(0, 5)), 8'($urandom)};
                set_req(a, (r < 4) || (r == 6), ((r >= 4) && (r < 7)), $urandom);
            end
            dram_rdata = $urandom;
            tick();
        end
        set_req(32'h0, 1'b0, 1'b0, 32'h0);
        repeat (8) tick();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/peri_bridge_n.md
PERI_BRIDGE_N -- requirements
Module: peri_bridge_n

Interface
REQ-001 SHALL have parameter DATA_W, default 32: bus and peripheral data width.
REQ-002 SHALL have parameter ADDR_W, default 32: CPU bus address width; legal range 16..32.
REQ-003 SHALL have parameter NUM_CH, default 4: number of I/O peripheral channels; legal range 1..16.
REQ-004 SHALL have parameter WBUF_DEPTH, default 4: posted-write buffer entries; power of two, at least 2.
REQ-005 SHALL have parameter IO_BASE, default all-ones: the I/O region match value for addr[ADDR_W-1:12].
REQ-006 SHALL have one clock and one reset; reset is asynchronous and active-low; ports: cpu_clk  in  1  clock; cpu_rst_n  in  1  asynchronous active-low reset.
REQ-007 SHALL have CPU-side ports: bus_addr in ADDR_W; bus_wen in 1; bus_ren in 1; bus_wdata in DATA_W; bus_ready out 1 (request accepted this cycle); bus_rvalid out 1 (read data valid); bus_rdata out DATA_W.
REQ-008 SHALL have DRAM ports: dram_addr out ADDR_W; dram_wen out 1; dram_wdata out DATA_W; dram_rdata in DATA_W.
REQ-009 SHALL have I/O ports: io_addr out 8 (channel-local offset); io_wen out NUM_CH (one-hot); io_wdata out DATA_W; io_rdata in NUM_CH*DATA_W (channel k at slice k).
REQ-010 SHALL have status ports: wbuf_level out clog2(WBUF_DEPTH)+1 (occupied entries); err_cnt out 8 (decode-error count).

Function
REQ-011 SHALL decode io_hit = (addr[ADDR_W-1:12] == IO_BASE), channel = addr[11:8], io_addr = addr[7:0]; a non-I/O address SHALL target DRAM.
REQ-012 SHALL treat an I/O address with channel >= NUM_CH as a decode error: write dropped, read returns 0, err_cnt incremented.
REQ-013 SHALL treat bus_wen and bus_ren asserted together as a decode error: write performed, read ignored, err_cnt incremented.
REQ-014 SHALL saturate err_cnt at 255.
REQ-015 SHALL pass DRAM accesses straight through: dram_addr = bus_addr, dram_wdata = bus_wdata, dram_wen = bus_wen & ~io_hit & bus_ready.
REQ-016 SHALL register read data: an accepted read in cycle N yields bus_rvalid = 1 for exactly cycle N+1, with bus_rdata from dram_rdata or the selected io_rdata slice.
REQ-017 SHALL hold bus_rdata stable from one read response until the next.
REQ-018 SHALL run a read FSM with states IDLE, WAIT_DRAIN, RESP: IDLE->RESP on an accepted read; IDLE->WAIT_DRAIN on an I/O read while the buffer is non-empty; WAIT_DRAIN->RESP once the buffer is empty; RESP->IDLE, or RESP->RESP on a back-to-back read.
REQ-019 SHALL hold bus_ready = 0 in WAIT_DRAIN; the CPU holds its request, and the read is accepted in the cycle the buffer becomes empty.
REQ-020 SHALL give io_addr the head buffer entry's offset while draining, and bus_addr[7:0] otherwise.

Reset
REQ-021 SHALL, while cpu_rst_n = 0, force bus_ready = 1, bus_rvalid = 0, bus_rdata = 0, io_wen = 0, wbuf_level = 0, err_cnt = 0, FSM = IDLE.
REQ-022 SHALL, on reset assertion mid-operation, discard all buffered writes without issuing them and abandon any pending read response.

Configuration
REQ-023 SHALL compile the posted-write buffer only when macro PERI_BRIDGE_WBUF_EN is defined.
REQ-024 SHALL, with PERI_BRIDGE_WBUF_EN, enqueue each valid I/O write {channel, offset, data} when not full; bus_ready = 0 on an I/O write while full.
REQ-025 SHALL, with PERI_BRIDGE_WBUF_EN, drain one entry per cycle from the head, asserting io_wen[channel] for one cycle with io_wdata = entry data.
REQ-026 SHALL, with PERI_BRIDGE_WBUF_EN, allow a simultaneous push and pop when not full, leaving wbuf_level unchanged and keeping FIFO order.
REQ-027 SHALL, without PERI_BRIDGE_WBUF_EN, drive io_wen[channel] = bus_wen & io_hit combinationally with io_wdata = bus_wdata, and tie wbuf_level to 0.
REQ-028 SHALL, without PERI_BRIDGE_WBUF_EN, never enter WAIT_DRAIN and never deassert bus_ready for writes.

Verification
REQ-029 SHALL cover: DRAM read of 0x0000_0010 with dram_rdata = 0x1234_5678 -> bus_rvalid = 1 one cycle later, bus_rdata = 0x1234_5678.
REQ-030 SHALL cover (WBUF_EN, depth 4): five back-to-back writes to 0xFFFF_F104 -> first four accepted, fifth stalls one cycle, then io_wen = 4'b0010 on five consecutive cycles in order.
REQ-031 SHALL cover (WBUF_EN): write 0xA5 to channel 2, then immediately read channel 2 -> bus_ready = 0 until drained, then response returns io_rdata slice 2.
REQ-032 SHALL cover: write to 0xFFFF_F700 with NUM_CH = 4 -> no io_wen pulse, err_cnt 0 -> 1; 300 such errors -> err_cnt = 255.
REQ-033 SHALL cover: cpu_rst_n low with 3 entries buffered -> wbuf_level = 0 immediately, and no io_wen pulse after release.
REQ-034 SHALL cover: bus_wen = bus_ren = 1 to DRAM 0x20 -> dram_wen = 1, no bus_rvalid, err_cnt incremented.
